acumulador_sat: RTL and testbench

ACUMULADOR_SAT -- requirements
Module: acumulador_sat

---
 rtl/acumulador_sat.sv | 145 ++++++++++++++
 tb/tb_acumulador_sat.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/acumulador_sat.sv
// Multi-channel signed accumulator with symmetric saturation, per-channel sticky
// overflow flags and a single-entry output register with ready/valid handshaking.
module acumulador_sat #(
   parameter int N  = 8,
   parameter int CH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             op,
   input  logic [$clog2(CH)-1:0]  ch_sel,
   input  logic signed [N-1:0]    data_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(CH)-1:0]  out_ch,
   output logic signed [N-1:0]    acc_out,
   output logic                   sat_pos,
   output logic                   sat_neg,
   output logic [CH-1:0]          ovf_sticky
);

   localparam int CW = $clog2(CH);
   localparam int EW = N + 2;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   // Symmetric range: the most negative N-bit code is never emitted.
   localparam logic signed [EW-1:0] SAT_MAX_X = {3'b000, {(N-1){1'b1}}};
   localparam logic signed [EW-1:0] SAT_MIN_X = -SAT_MAX_X;
   localparam logic signed [N-1:0]  SAT_MAX_N = {1'b0, {(N-1){1'b1}}};
   localparam logic signed [N-1:0]  SAT_MIN_N = {1'b1, {(N-2){1'b0}}, 1'b1};

   function automatic logic is_over(input logic signed [EW-1:0] v);
      return v > SAT_MAX_X;
   endfunction

   function automatic logic is_under(input logic signed [EW-1:0] v);
      return v < SAT_MIN_X;
   endfunction

   function automatic logic signed [N-1:0] clamp(input logic signed [EW-1:0] v);
      logic signed [N-1:0] r;
      if (is_over(v))
         r = SAT_MAX_N;
      else if (is_under(v))
         r = SAT_MIN_N;
      else
         r = v[N-1:0];
      return r;
   endfunction

   logic signed [N-1:0] acc_q [CH];
   logic signed [N-1:0] acc_d [CH];
   logic [CH-1:0]       sticky_q, sticky_d;
   logic                out_valid_q, out_valid_d;
   logic [CW-1:0]       out_ch_q, out_ch_d;
   logic signed [N-1:0] acc_out_q, acc_out_d;
   logic                sat_pos_q, sat_pos_d;
   logic                sat_neg_q, sat_neg_d;

   logic                accept;
   logic signed [N-1:0] acc_sel;
   logic signed [EW-1:0] acc_ext;
   logic signed [EW-1:0] din_ext;
   logic signed [EW-1:0] exact;
   logic                 ovr, und;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   assign acc_sel = acc_q[ch_sel];
   assign acc_ext = {{2{acc_sel[N-1]}}, acc_sel};
   assign din_ext = {{2{data_in[N-1]}}, data_in};

   // Two guard bits keep every operation exact, including acc - (-2^(N-1)).
   always_comb begin
      exact = '0;
      unique case (op)
         OP_LOAD:  exact = din_ext;
         OP_ADD:   exact = acc_ext + din_ext;
         OP_SUB:   exact = acc_ext - din_ext;
         OP_CLEAR: exact = '0;
         default:  exact = '0;
      endcase
   end

   assign ovr = is_over(exact);
   assign und = is_under(exact);

   always_comb begin
      acc_d       = acc_q;
      sticky_d    = sticky_q;
      out_valid_d = out_valid_q && !out_ready;
      out_ch_d    = out_ch_q;
      acc_out_d   = acc_out_q;
      sat_pos_d   = sat_pos_q;
      sat_neg_d   = sat_neg_q;
      if (accept) begin
         acc_d[ch_sel] = clamp(exact);
         if (op == OP_CLEAR)
            sticky_d[ch_sel] = 1'b0;
         else if (ovr || und)
            sticky_d[ch_sel] = 1'b1;
         out_valid_d = 1'b1;
         out_ch_d    = ch_sel;
         acc_out_d   = clamp(exact);
         sat_pos_d   = ovr;
         sat_neg_d   = und;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CH; i++)
            acc_q[i] <= '0;
         sticky_q    <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         acc_out_q   <= '0;
         sat_pos_q   <= 1'b0;
         sat_neg_q   <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++)
            acc_q[i] <= acc_d[i];
         sticky_q    <= sticky_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         acc_out_q   <= acc_out_d;
         sat_pos_q   <= sat_pos_d;
         sat_neg_q   <= sat_neg_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_ch     = out_ch_q;
   assign acc_out    = acc_out_q;
   assign sat_pos    = sat_pos_q;
   assign sat_neg    = sat_neg_q;
   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_acumulador_sat.sv
// Randomized and directed bench for acumulador_sat against an integer reference model.
module tb_acumulador_sat;

   localparam int N  = 8;
   localparam int CH = 4;
   localparam int SMAX = 127;
   localparam int SMIN = -127;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        op = 2'b00;
   logic [1:0]        ch_sel = 2'b00;
   logic signed [7:0] data_in = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [1:0]        out_ch;
   logic signed [7:0] acc_out;
   logic              sat_pos, sat_neg;
   logic [3:0]        ovf_sticky;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_acc [CH];
   int m_sticky [CH];
   int m_valid, m_out, m_ch, m_sp, m_sn;

   acumulador_sat #(.N(N), .CH(CH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .ch_sel(ch_sel), .data_in(data_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch), .acc_out(acc_out),
      .sat_pos(sat_pos), .sat_neg(sat_neg), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int sticky_vec();
      int v = 0;
      for (int i = 0; i < CH; i++)
         if (m_sticky[i] != 0) v += (1 << i);
      return v;
   endfunction

   task automatic step(input logic v, input logic [1:0] o, input int ch, input int d,
                       input logic ordy, input logic rst);
      int e, r, acc_now;
      @(negedge clk);
      in_valid  = v;
      op        = o;
      ch_sel    = 2'(ch);
      data_in   = 8'(d);
      out_ready = ordy;
      reset     = rst;
      #1;
      acc_now = v && (m_valid == 0 || ordy) && !rst;
      if (!rst) chk("in_ready", in_ready, (m_valid == 0 || ordy) ? 1 : 0);
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            m_acc[i] = 0;
            m_sticky[i] = 0;
         end
         m_valid = 0; m_out = 0; m_ch = 0; m_sp = 0; m_sn = 0;
      end else if (acc_now) begin
         case (o)
            2'b00:   e = d;
            2'b01:   e = m_acc[ch] + d;
            2'b10:   e = m_acc[ch] - d;
            default: e = 0;
         endcase
         r = (e > SMAX) ? SMAX : (e < SMIN) ? SMIN : e;
         m_acc[ch] = r;
         if (o == 2'b11) m_sticky[ch] = 0;
         else if (e > SMAX || e < SMIN) m_sticky[ch] = 1;
         m_valid = 1; m_out = r; m_ch = ch;
         m_sp = (e > SMAX) ? 1 : 0;
         m_sn = (e < SMIN) ? 1 : 0;
      end else if (ordy) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, m_valid);
      chk("acc_out", acc_out, m_out);
      chk("out_ch", out_ch, m_ch);
      chk("sat_pos", sat_pos, m_sp);
      chk("sat_neg", sat_neg, m_sn);
      chk("ovf_sticky", ovf_sticky, sticky_vec());
   endtask

   initial begin
      for (int i = 0; i < CH; i++) begin
         m_acc[i] = 0;
         m_sticky[i] = 0;
      end
      m_valid = 0; m_out = 0; m_ch = 0; m_sp = 0; m_sn = 0;

      step(0, 2'b00, 0, 0, 0, 1);
      step(0, 2'b00, 0, 0, 0, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_sticky", ovf_sticky, 0);

      for (int c = 0; c < CH; c++) begin
         step(1, 2'b01, c, 0, 1, 0);
         chk("add0", acc_out, 0);
      end

      // Saturation on channel 0
      step(1, 2'b00, 0, 100, 1, 0);
      chk("load100", acc_out, 100);
      step(1, 2'b01, 0, 50, 1, 0);
      chk("add50", acc_out, 127);
      chk("add50_sp", sat_pos, 1);
      chk("add50_sticky", ovf_sticky[0], 1);
      step(1, 2'b01, 0, -27, 1, 0);
      chk("addm27", acc_out, 100);
      chk("addm27_sp", sat_pos, 0);
      chk("addm27_sticky", ovf_sticky[0], 1);

      step(1, 2'b00, 1, -100, 1, 0);
      step(1, 2'b10, 1, 100, 1, 0);
      chk("sub_neg", acc_out, -127);
      chk("sub_neg_sn", sat_neg, 1);
      step(1, 2'b10, 2, -128, 1, 0);
      chk("sub_min", acc_out, 127);
      chk("sub_min_sp", sat_pos, 1);
      step(1, 2'b00, 3, -128, 1, 0);
      chk("load_min", acc_out, -127);
      chk("load_min_sn", sat_neg, 1);

      // Back-to-back chaining
      step(1, 2'b00, 2, 0, 1, 0);
      for (int k = 1; k <= 3; k++) begin
         step(1, 2'b01, 2, 1, 1, 0);
         chk("chain", acc_out, k);
      end

      // Stall: result held while consumer is not ready
      step(0, 2'b00, 0, 0, 1, 0);
      step(1, 2'b01, 1, 5, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 2'b00, 3, 55, 0, 0);
         chk("stall_ready", in_ready, 0);
         chk("stall_acc", acc_out, -122);
      end
      step(1, 2'b00, 3, 55, 1, 0);
      chk("resume_valid", out_valid, 1);
      chk("resume_acc", acc_out, 55);

      step(1, 2'b11, 0, 0, 1, 0);
      chk("clear_acc", acc_out, 0);
      chk("clear_sticky", ovf_sticky, 4'b1110);

      step(1, 2'b01, 1, 1, 0, 0);
      step(1, 2'b01, 1, 1, 0, 1);
      chk("rst_drop", out_valid, 0);

      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 255)) - 128,
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
